// File: rtl/nn_cfg_loader.sv
// Streams one weight/bias image onto the layer write bus, layer by neuron by weight.
// Define NN_CFG_CHECKSUM_EN to append and verify a trailing wrap-around sum word.
module nn_cfg_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int L1_NEURONS = 30,
  parameter int L1_WEIGHTS = 784,
  parameter int L2_NEURONS = 30,
  parameter int L2_WEIGHTS = 30,
  parameter int L3_NEURONS = 10,
  parameter int L3_WEIGHTS = 30,
  parameter int L4_NEURONS = 10,
  parameter int L4_WEIGHTS = 10
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] cfg_tdata,
  input  logic                  cfg_tvalid,
  output logic                  cfg_tready,
  output logic [31:0]           layerNumber,
  output logic [31:0]           neuronNumber,
  output logic [DATA_WIDTH-1:0] weightValue,
  output logic                  weightValid,
  output logic [DATA_WIDTH-1:0] biasValue,
  output logic                  biasValid,
  output logic                  busy,
  output logic                  done,
  output logic                  loaded,
  output logic                  cfg_err
);

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXV = max2(
    max2(max2(L1_NEURONS, L1_WEIGHTS), max2(L2_NEURONS, L2_WEIGHTS)),
    max2(max2(L3_NEURONS, L3_WEIGHTS), max2(L4_NEURONS, L4_WEIGHTS)));
  localparam int CW = $clog2(MAXV + 1);

`ifdef NN_CFG_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WEIGHT, S_BIAS, S_CHECK, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WEIGHT, S_BIAS, S_DONE
  } state_t;
`endif

  state_t                state_q;
  logic [2:0]            layer_q;
  logic [CW-1:0]         neuron_q;
  logic [CW-1:0]         wcnt_q;
  logic [31:0]           lnum_q;
  logic [31:0]           nnum_q;
  logic [DATA_WIDTH-1:0] wval_q;
  logic [DATA_WIDTH-1:0] bval_q;
  logic                  wvld_q;
  logic                  bvld_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  loaded_q;
  logic [CW-1:0]         n_lim;
  logic [CW-1:0]         w_lim;
  logic                  hs;

  always_comb begin
    n_lim = CW'(L1_NEURONS - 1);
    w_lim = CW'(L1_WEIGHTS - 1);
    unique case (1'b1)
      layer_q == 3'd2: begin
        n_lim = CW'(L2_NEURONS - 1);
        w_lim = CW'(L2_WEIGHTS - 1);
      end
      layer_q == 3'd3: begin
        n_lim = CW'(L3_NEURONS - 1);
        w_lim = CW'(L3_WEIGHTS - 1);
      end
      layer_q == 3'd4: begin
        n_lim = CW'(L4_NEURONS - 1);
        w_lim = CW'(L4_WEIGHTS - 1);
      end
      default: ;
    endcase
  end

  assign cfg_tready = (state_q == S_WEIGHT) || (state_q == S_BIAS)
`ifdef NN_CFG_CHECKSUM_EN
                    || (state_q == S_CHECK)
`endif
                    ;
  assign hs = cfg_tvalid & cfg_tready;

`ifdef NN_CFG_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q;
  logic                  err_q;
  assign cfg_err = err_q;
`else
  assign cfg_err = 1'b0;
`endif

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q  <= S_IDLE;
      layer_q  <= '0;
      neuron_q <= '0;
      wcnt_q   <= '0;
      lnum_q   <= '0;
      nnum_q   <= '0;
      wval_q   <= '0;
      bval_q   <= '0;
      wvld_q   <= 1'b0;
      bvld_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      loaded_q <= 1'b0;
`ifdef NN_CFG_CHECKSUM_EN
      sum_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      wvld_q <= 1'b0;
      bvld_q <= 1'b0;
      done_q <= 1'b0;
      if (abort) begin
        state_q  <= S_IDLE;
        layer_q  <= '0;
        neuron_q <= '0;
        wcnt_q   <= '0;
        busy_q   <= 1'b0;
        loaded_q <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE, S_DONE: begin
            if (start) begin
              state_q  <= S_WEIGHT;
              layer_q  <= 3'd1;
              neuron_q <= '0;
              wcnt_q   <= '0;
              busy_q   <= 1'b1;
              loaded_q <= 1'b0;
`ifdef NN_CFG_CHECKSUM_EN
              sum_q    <= '0;
              err_q    <= 1'b0;
`endif
            end
          end
          S_WEIGHT: begin
            if (hs) begin
              wval_q <= cfg_tdata;
              wvld_q <= 1'b1;
              lnum_q <= 32'(layer_q);
              nnum_q <= 32'(neuron_q);
`ifdef NN_CFG_CHECKSUM_EN
              sum_q  <= sum_q + cfg_tdata;
`endif
              if (wcnt_q == w_lim) begin
                wcnt_q  <= '0;
                state_q <= S_BIAS;
              end else begin
                wcnt_q  <= wcnt_q + CW'(1);
              end
            end
          end
          S_BIAS: begin
            if (hs) begin
              bval_q <= cfg_tdata;
              bvld_q <= 1'b1;
              lnum_q <= 32'(layer_q);
              nnum_q <= 32'(neuron_q);
`ifdef NN_CFG_CHECKSUM_EN
              sum_q  <= sum_q + cfg_tdata;
`endif
              if (neuron_q != n_lim) begin
                neuron_q <= neuron_q + CW'(1);
                state_q  <= S_WEIGHT;
              end else if (layer_q != 3'd4) begin
                layer_q  <= layer_q + 3'd1;
                neuron_q <= '0;
                state_q  <= S_WEIGHT;
              end else begin
`ifdef NN_CFG_CHECKSUM_EN
                state_q  <= S_CHECK;
`else
                state_q  <= S_DONE;
                done_q   <= 1'b1;
                busy_q   <= 1'b0;
                loaded_q <= 1'b1;
`endif
              end
            end
          end
`ifdef NN_CFG_CHECKSUM_EN
          S_CHECK: begin
            if (hs) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              loaded_q <= (cfg_tdata == sum_q);
              err_q    <= (cfg_tdata != sum_q);
            end
          end
`endif
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign layerNumber  = lnum_q;
  assign neuronNumber = nnum_q;
  assign weightValue  = wval_q;
  assign biasValue    = bval_q;
  assign weightValid  = wvld_q;
  assign biasValid    = bvld_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign loaded       = loaded_q;

endmodule

// File: tb/tb_nn_cfg_loader.sv
// Bench for nn_cfg_loader: scenario tasks against a queue-based image model.
// Checksum scenarios run only when NN_CFG_CHECKSUM_EN is defined.
module tb_nn_cfg_loader;

  localparam int DW = 32;
  localparam int N1 = 2, W1 = 3, N2 = 2, W2 = 2;
  localparam int N3 = 1, W3 = 2, N4 = 1, W4 = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] cfg_tdata = '0;
  logic          cfg_tvalid = 1'b0;
  logic          cfg_tready;
  logic [31:0]   layerNumber, neuronNumber;
  logic [DW-1:0] weightValue, biasValue;
  logic          weightValid, biasValid;
  logic          busy, done, loaded, cfg_err;

  nn_cfg_loader #(
    .DATA_WIDTH(DW),
    .L1_NEURONS(N1), .L1_WEIGHTS(W1),
    .L2_NEURONS(N2), .L2_WEIGHTS(W2),
    .L3_NEURONS(N3), .L3_WEIGHTS(W3),
    .L4_NEURONS(N4), .L4_WEIGHTS(W4)
  ) dut (
    .s_axi_aclk(clk),
    .s_axi_aresetn(rst_n),
    .start(start),
    .abort(abort),
    .cfg_tdata(cfg_tdata),
    .cfg_tvalid(cfg_tvalid),
    .cfg_tready(cfg_tready),
    .layerNumber(layerNumber),
    .neuronNumber(neuronNumber),
    .weightValue(weightValue),
    .weightValid(weightValid),
    .biasValue(biasValue),
    .biasValid(biasValid),
    .busy(busy),
    .done(done),
    .loaded(loaded),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_b;
    int          l;
    int          n;
    logic [31:0] v;
    time         t;
  } ev_t;

  int          NEU [4] = '{N1, N2, N3, N4};
  int          WTS [4] = '{W1, W2, W3, W4};
  logic [31:0] img [$];
  ev_t         exp_q [$];
  ev_t         obs [$];
  logic [31:0] total_sum;
  int          exp_w, exp_b;
  time         last_hs_t;
  time         done_t;
  int          done_cnt;
  int          ncmp = 0;
  int          nfail = 0;

  always @(negedge clk) begin
    ev_t e;
    if (weightValid || biasValid) begin
      e.is_b = biasValid;
      e.l    = int'(layerNumber);
      e.n    = int'(neuronNumber);
      e.v    = biasValid ? biasValue : weightValue;
      e.t    = $time;
      obs.push_back(e);
    end
    if (done) begin
      done_cnt++;
      done_t = $time;
    end
  end

  // kind 0: words 1..N in order; kind 1: random words
  task automatic build(input int kind);
    ev_t e;
    logic [31:0] v;
    int k = 0;
    img.delete();
    exp_q.delete();
    total_sum = 0;
    exp_w = 0;
    exp_b = 0;
    for (int l = 1; l <= 4; l++) begin
      for (int n = 0; n < NEU[l-1]; n++) begin
        for (int w = 0; w <= WTS[l-1]; w++) begin
          k++;
          v = (kind == 0) ? 32'(k) : $urandom;
          e.is_b = (w == WTS[l-1]);
          e.l = l;
          e.n = n;
          e.v = v;
          e.t = 0;
          img.push_back(v);
          exp_q.push_back(e);
          total_sum += v;
          if (e.is_b) exp_b++;
          else exp_w++;
        end
      end
    end
  endtask

  function automatic int first_diff(input int n);
    for (int i = 0; i < n; i++) begin
      if (i >= obs.size() || i >= exp_q.size()) return i;
      if (obs[i].is_b !== exp_q[i].is_b || obs[i].l !== exp_q[i].l ||
          obs[i].n !== exp_q[i].n || obs[i].v !== exp_q[i].v)
        return i;
    end
    return -1;
  endfunction

  task automatic do_start();
    @(negedge clk);
    obs.delete();
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0 continuous, 1 toggling, 2 random gaps
  task automatic drive(input int mode, input int start_at, input int max_words);
    int idx = 0;
    int budget = 2000;
    bit ph = 1'b0;
    int lim = (max_words < img.size()) ? max_words : img.size();
    while (idx < lim && budget > 0) begin
      budget--;
      cfg_tvalid = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(0, 1));
      ph = ~ph;
      cfg_tdata = img[idx];
      start = (idx == start_at);
      if (cfg_tvalid && cfg_tready) begin
        idx++;
        last_hs_t = $time;
      end
      @(negedge clk);
    end
    cfg_tvalid = 1'b0;
    start = 1'b0;
    if (budget == 0) begin
      ncmp++;
      nfail++;
      $display("FAIL drive_timeout: accepted %0d words, required %0d", idx, lim);
    end
  endtask

  task automatic push_checksum(input logic [31:0] v);
`ifdef NN_CFG_CHECKSUM_EN
    img.push_back(v);
`else
    if (v === 32'hx) $display("unused");
`endif
  endtask

  task automatic test_reset();
    #1;
    ncmp++;
    if ({cfg_tready, weightValid, biasValid, busy, done, loaded, cfg_err} !== 7'b0) begin
      nfail++;
      $display("FAIL reset_flags: got %b, required 0000000",
        {cfg_tready, weightValid, biasValid, busy, done, loaded, cfg_err});
    end
    ncmp++;
    if ({layerNumber, neuronNumber, weightValue, biasValue} !== '0) begin
      nfail++;
      $display("FAIL reset_values: got l=%0d n=%0d w=%h b=%h, required all 0",
        layerNumber, neuronNumber, weightValue, biasValue);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    ncmp++;
    if (cfg_tready !== 1'b0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL idle_ready: tready=%b busy=%b, required 0 0", cfg_tready, busy);
    end
  endtask

  task automatic test_continuous();
    int d;
    int nw = 0, nb = 0;
    build(0);
    push_checksum(total_sum);
    do_start();
    ncmp++;
    if (cfg_tready !== 1'b1 || busy !== 1'b1) begin
      nfail++;
      $display("FAIL start_latency: tready=%b busy=%b, required 1 1", cfg_tready, busy);
    end
    drive(0, -1, 1000);
    repeat (2) @(negedge clk);
    d = first_diff(exp_q.size());
    ncmp++;
    if (d !== -1 || obs.size() !== exp_q.size()) begin
      nfail++;
      $display("FAIL cont_stream: first diff at %0d, got %0d strobes, required %0d",
        d, obs.size(), exp_q.size());
    end
    foreach (obs[i]) if (obs[i].is_b) nb++; else nw++;
    ncmp++;
    if (nw !== exp_w || nb !== exp_b) begin
      nfail++;
      $display("FAIL cont_counts: got %0d w / %0d b, required %0d / %0d", nw, nb, exp_w, exp_b);
    end
    ncmp++;
    if (obs.size() < 4 || obs[0].is_b || obs[0].l !== 1 || obs[0].n !== 0 || obs[0].v !== 32'd1) begin
      nfail++;
      $display("FAIL first_weight: size %0d, required weight l1 n0 v1", obs.size());
    end else begin
      ncmp++;
      if (!obs[3].is_b || obs[3].l !== 1 || obs[3].n !== 0 || obs[3].v !== 32'd4) begin
        nfail++;
        $display("FAIL word4_bias: got b=%0d l=%0d n=%0d v=%0d, required 1 1 0 4",
          obs[3].is_b, obs[3].l, obs[3].n, obs[3].v);
      end
      ncmp++;
      if (!obs[$].is_b || obs[$].l !== 4 || obs[$].n !== 0 || obs[$].v !== 32'(exp_w + exp_b)) begin
        nfail++;
        $display("FAIL last_bias: got b=%0d l=%0d n=%0d v=%0d, required 1 4 0 %0d",
          obs[$].is_b, obs[$].l, obs[$].n, obs[$].v, exp_w + exp_b);
      end
      ncmp++;
      if (obs[$].t - obs[0].t !== time'((obs.size() - 1) * 10)) begin
        nfail++;
        $display("FAIL cont_throughput: span %0t, required %0d", obs[$].t - obs[0].t,
          (obs.size() - 1) * 10);
      end
    end
    ncmp++;
    if (done_cnt !== 1 || done_t !== last_hs_t + 10) begin
      nfail++;
      $display("FAIL cont_done: count %0d at %0t, required 1 at %0t", done_cnt, done_t, last_hs_t + 10);
    end
    ncmp++;
    if (loaded !== 1'b1 || busy !== 1'b0 || cfg_err !== 1'b0) begin
      nfail++;
      $display("FAIL cont_status: loaded=%b busy=%b err=%b, required 1 0 0", loaded, busy, cfg_err);
    end
  endtask

  task automatic test_toggle();
    int d;
    build(0);
    push_checksum(total_sum);
    do_start();
    drive(1, -1, 1000);
    repeat (2) @(negedge clk);
    d = first_diff(exp_q.size());
    ncmp++;
    if (d !== -1 || obs.size() !== exp_q.size()) begin
      nfail++;
      $display("FAIL toggle_stream: first diff at %0d, got %0d strobes", d, obs.size());
    end else begin
      ncmp++;
      if (obs[$].t - obs[0].t !== time'((obs.size() - 1) * 20)) begin
        nfail++;
        $display("FAIL toggle_span: got %0t, required %0d", obs[$].t - obs[0].t, (obs.size() - 1) * 20);
      end
    end
    ncmp++;
    if (done_cnt !== 1 || loaded !== 1'b1) begin
      nfail++;
      $display("FAIL toggle_done: count %0d loaded %b, required 1 1", done_cnt, loaded);
    end
  endtask

  task automatic test_random_gaps();
    int d;
    for (int r = 0; r < 3; r++) begin
      build(1);
      push_checksum(total_sum);
      do_start();
      drive(2, -1, 1000);
      repeat (2) @(negedge clk);
      d = first_diff(exp_q.size());
      ncmp++;
      if (d !== -1 || obs.size() !== exp_q.size() || done_cnt !== 1 || loaded !== 1'b1) begin
        nfail++;
        $display("FAIL random_load: run %0d diff %0d strobes %0d done %0d loaded %b", r, d,
          obs.size(), done_cnt, loaded);
      end
    end
  endtask

  task automatic test_start_midload();
    int d;
    build(1);
    push_checksum(total_sum);
    do_start();
    drive(0, 5, 1000);
    repeat (2) @(negedge clk);
    d = first_diff(exp_q.size());
    ncmp++;
    if (d !== -1 || obs.size() !== exp_q.size() || done_cnt !== 1) begin
      nfail++;
      $display("FAIL start_ignored: diff %0d strobes %0d done %0d, required -1 %0d 1", d,
        obs.size(), exp_q.size(), done_cnt);
    end
  endtask

  task automatic test_abort();
    int d;
    build(1);
    do_start();
    drive(0, -1, 7);
    abort = 1'b1;
    cfg_tvalid = 1'b1;
    cfg_tdata = img[7];
    @(negedge clk);
    abort = 1'b0;
    ncmp++;
    if (cfg_tready !== 1'b0 || busy !== 1'b0 || loaded !== 1'b0) begin
      nfail++;
      $display("FAIL abort_idle: tready=%b busy=%b loaded=%b, required 0 0 0",
        cfg_tready, busy, loaded);
    end
    repeat (4) @(negedge clk);
    cfg_tvalid = 1'b0;
    d = first_diff(7);
    ncmp++;
    if (obs.size() !== 7 || d !== -1) begin
      nfail++;
      $display("FAIL abort_strobes: got %0d strobes diff %0d, required 7 -1", obs.size(), d);
    end
    build(1);
    push_checksum(total_sum);
    do_start();
    drive(2, -1, 1000);
    repeat (2) @(negedge clk);
    d = first_diff(exp_q.size());
    ncmp++;
    if (d !== -1 || obs.size() !== exp_q.size() || done_cnt !== 1 || loaded !== 1'b1) begin
      nfail++;
      $display("FAIL abort_reload: diff %0d strobes %0d done %0d loaded %b", d, obs.size(),
        done_cnt, loaded);
    end
  endtask

`ifdef NN_CFG_CHECKSUM_EN
  task automatic test_checksum();
    build(0);
    push_checksum(total_sum);
    do_start();
    drive(0, -1, 1000);
    repeat (2) @(negedge clk);
    ncmp++;
    if (cfg_err !== 1'b0 || loaded !== 1'b1 || done_cnt !== 1) begin
      nfail++;
      $display("FAIL csum_good: err=%b loaded=%b done %0d, required 0 1 1", cfg_err, loaded, done_cnt);
    end
    build(0);
    push_checksum(total_sum - 32'd1);
    do_start();
    drive(0, -1, 1000);
    repeat (2) @(negedge clk);
    ncmp++;
    if (cfg_err !== 1'b1 || loaded !== 1'b0 || done_cnt !== 1 || done_t !== last_hs_t + 10) begin
      nfail++;
      $display("FAIL csum_bad: err=%b loaded=%b done %0d at %0t, required 1 0 1 at %0t",
        cfg_err, loaded, done_cnt, done_t, last_hs_t + 10);
    end
  endtask
`endif

  task automatic test_async_reset();
    build(0);
    push_checksum(total_sum);
    do_start();
    drive(0, -1, 6);
    #3;
    rst_n = 1'b0;
    #1;
    ncmp++;
    if ({cfg_tready, weightValid, biasValid, busy, done, loaded, cfg_err} !== 7'b0 ||
        {layerNumber, neuronNumber, weightValue, biasValue} !== '0) begin
      nfail++;
      $display("FAIL async_reset: tready=%b busy=%b l=%0d n=%0d w=%h b=%h, required all 0",
        cfg_tready, busy, layerNumber, neuronNumber, weightValue, biasValue);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_start();
    drive(0, -1, 1000);
    repeat (2) @(negedge clk);
    ncmp++;
    if (done_cnt !== 1 || loaded !== 1'b1 || obs.size() !== exp_q.size()) begin
      nfail++;
      $display("FAIL post_reset_load: done %0d loaded %b strobes %0d", done_cnt, loaded, obs.size());
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_toggle();
    test_random_gaps();
    test_start_midload();
    test_abort();
`ifdef NN_CFG_CHECKSUM_EN
    test_checksum();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
